// File: rtl/bird_physics_if.sv
// -----------------------------------------------------------------------------
// bird_physics_if
// Bundles the game-side signals of the bird motion engine.
//   game_rst   : restart request for a new game (driven by game control)
//   mouse_left : raw left mouse button level
//   BIRD_Y     : bird top edge in pixels (to draw and collision logic)
//   bird_vel   : signed vertical velocity, px/tick, negative = upward
//   flying     : bird is in flight
//   grounded   : bird has landed on the floor (game over)
//   hit_floor  : single-cycle pulse when the bird lands
// master drives the inputs and observes the outputs; slave is the engine.
// -----------------------------------------------------------------------------
interface bird_physics_if;
   logic              game_rst;
   logic              mouse_left;
   logic [10:0]       BIRD_Y;
   logic signed [7:0] bird_vel;
   logic              flying;
   logic              grounded;
   logic              hit_floor;

   modport master (
      output game_rst, mouse_left,
      input  BIRD_Y, bird_vel, flying, grounded, hit_floor
   );

   modport slave (
      input  game_rst, mouse_left,
      output BIRD_Y, bird_vel, flying, grounded, hit_floor
   );
endinterface

// File: rtl/bird_physics.sv
// -----------------------------------------------------------------------------
// bird_physics
// Gravity/impulse motion engine for the bird's vertical position. A click on
// the left mouse button loads an upward velocity; every physics tick gravity
// pulls the velocity down towards a terminal fall speed and the position is
// advanced. The bird is clamped at the ceiling and stops dead on the floor.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : bird_physics_if.slave (game_rst, mouse_left in;
//          BIRD_Y, bird_vel, flying, grounded, hit_floor out)
// -----------------------------------------------------------------------------
module bird_physics #(
   parameter int SCREEN_HEIGHT = 768,
   parameter int BIRD_HEIGHT   = 100,
   parameter int START_Y       = 300,
   parameter int TICK_DIV      = 1_000_000,
   parameter int GRAVITY       = 1,
   parameter int JUMP_VEL      = 6,
   parameter int MAX_FALL      = 8
) (
   input  logic          clk,
   input  logic          rst,
   bird_physics_if.slave bus
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TICK_DIV - 1);
   localparam logic [10:0]        Y_START   = 11'(START_Y);
   localparam logic [10:0]        Y_FLOOR   = 11'(SCREEN_HEIGHT - BIRD_HEIGHT);
   localparam logic signed [12:0] Y_FLOOR13 = 13'(SCREEN_HEIGHT - BIRD_HEIGHT);
   localparam logic signed [7:0]  VEL_JUMP  = 8'(-JUMP_VEL);
   localparam logic signed [8:0]  GRAV9     = 9'(GRAVITY);
   localparam logic signed [8:0]  MAXF9     = 9'(MAX_FALL);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FLY  = 2'd1,
      S_DEAD = 2'd2
   } state_t;

   state_t            r_state, w_state_nxt;
   logic              r_mouse_d;
   logic              r_click;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [10:0]       r_y, w_y_nxt;
   logic signed [7:0] r_vel, w_vel_nxt;
   logic              r_hit, w_hit_nxt;

   logic              w_reset;
   logic              w_tick;
   logic signed [12:0] w_y_next;

   // Gravity step with saturation at the terminal fall speed.
   function automatic logic signed [7:0] sat_fall(input logic signed [7:0] v);
      logic signed [8:0] s;
      s = $signed({v[7], v}) + GRAV9;
      if (s > MAXF9) begin
         sat_fall = MAXF9[7:0];
      end else begin
         sat_fall = s[7:0];
      end
   endfunction

   assign w_reset  = rst | bus.game_rst;
   assign w_tick   = (r_cnt == CNT_LAST);
   // Candidate position widened to 13 bits signed so both ceiling underflow
   // and floor overshoot are visible before clamping.
   assign w_y_next = $signed({2'b00, r_y}) + $signed({{5{r_vel[7]}}, r_vel});

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_y_nxt     = r_y;
      w_vel_nxt   = r_vel;
      w_hit_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_y_nxt   = Y_START;
            w_vel_nxt = '0;
            w_cnt_nxt = '0;
            if (r_click) begin
               w_state_nxt = S_FLY;
               w_vel_nxt   = VEL_JUMP;
            end
         end
         S_FLY: begin
            w_cnt_nxt = w_tick ? '0 : r_cnt + CNT_W'(1);
            if (w_tick) begin
               // Position always moves with the pre-click velocity; a
               // coincident click only replaces the new velocity, and a
               // floor landing overrides the click.
               if (w_y_next[12]) begin
                  w_y_nxt   = '0;
                  w_vel_nxt = r_click ? VEL_JUMP : 8'sd0;
               end else if (w_y_next >= Y_FLOOR13) begin
                  w_y_nxt     = Y_FLOOR;
                  w_vel_nxt   = '0;
                  w_state_nxt = S_DEAD;
                  w_hit_nxt   = 1'b1;
               end else begin
                  w_y_nxt   = w_y_next[10:0];
                  w_vel_nxt = r_click ? VEL_JUMP : sat_fall(r_vel);
               end
            end else if (r_click) begin
               w_vel_nxt = VEL_JUMP;
            end
         end
         S_DEAD: begin
            w_state_nxt = S_DEAD;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_reset) begin
         r_state   <= S_IDLE;
         r_mouse_d <= 1'b0;
         r_click   <= 1'b0;
         r_cnt     <= '0;
         r_y       <= Y_START;
         r_vel     <= '0;
         r_hit     <= 1'b0;
      end else begin
         r_mouse_d <= bus.mouse_left;
         // Registered rising edge: a held button yields one click.
         r_click   <= bus.mouse_left & ~r_mouse_d;
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_y       <= w_y_nxt;
         r_vel     <= w_vel_nxt;
         r_hit     <= w_hit_nxt;
      end
   end

   assign bus.BIRD_Y    = r_y;
   assign bus.bird_vel  = r_vel;
   assign bus.flying    = (r_state == S_FLY);
   assign bus.grounded  = (r_state == S_DEAD);
   assign bus.hit_floor = r_hit;

endmodule

// File: tb/tb_bird_physics.sv
// -----------------------------------------------------------------------------
// tb_bird_physics
// Three engines with TICK_DIV=4 and different start heights share one stimulus
// stream; each is compared every cycle against a behavioural model, and the
// key trajectories are also checked against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_bird_physics;

   localparam int TD = 4;
   localparam int SH = 768;
   localparam int BH = 100;
   localparam int JV = 6;
   localparam int GV = 1;
   localparam int MF = 8;
   localparam int ST_IDLE = 0;
   localparam int ST_FLY  = 1;
   localparam int ST_DEAD = 2;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   bird_physics_if u_if_a ();
   bird_physics_if u_if_b ();
   bird_physics_if u_if_c ();

   bird_physics #(.START_Y(300), .TICK_DIV(TD)) u_dut_a (.clk(clk), .rst(rst), .bus(u_if_a));
   bird_physics #(.START_Y(3),   .TICK_DIV(TD)) u_dut_b (.clk(clk), .rst(rst), .bus(u_if_b));
   bird_physics #(.START_Y(418), .TICK_DIV(TD)) u_dut_c (.clk(clk), .rst(rst), .bus(u_if_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model state, one slot per engine.
   int start_y [3] = '{300, 3, 418};
   int m_y   [3];
   int m_v   [3];
   int m_st  [3];
   int m_cnt [3];
   int m_hit [3];
   bit m_prev[3];
   bit m_clk [3];

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step_model(input int i, input bit rs, input bit mouse);
      bit click;
      int yn, vn;
      if (rs) begin
         m_y[i] = start_y[i]; m_v[i] = 0; m_st[i] = ST_IDLE; m_cnt[i] = 0;
         m_hit[i] = 0; m_prev[i] = 0; m_clk[i] = 0;
         return;
      end
      click    = m_clk[i];
      m_clk[i] = mouse & ~m_prev[i];
      m_prev[i] = mouse;
      m_hit[i] = 0;
      if (m_st[i] == ST_IDLE) begin
         if (click) begin
            m_st[i] = ST_FLY; m_v[i] = -JV; m_cnt[i] = 0;
         end
      end else if (m_st[i] == ST_FLY) begin
         if (m_cnt[i] == TD - 1) begin
            m_cnt[i] = 0;
            yn = m_y[i] + m_v[i];
            vn = (m_v[i] + GV > MF) ? MF : m_v[i] + GV;
            if (yn < 0) begin
               m_y[i] = 0; m_v[i] = click ? -JV : 0;
            end else if (yn + BH >= SH) begin
               m_y[i] = SH - BH; m_v[i] = 0; m_st[i] = ST_DEAD; m_hit[i] = 1;
            end else begin
               m_y[i] = yn; m_v[i] = click ? -JV : vn;
            end
         end else begin
            m_cnt[i] = m_cnt[i] + 1;
            if (click) m_v[i] = -JV;
         end
      end
   endtask

   task automatic cmp_one(input int i, input int y, input int v, input logic fl,
                          input logic gr, input logic hit);
      check($sformatf("model_y%0d", i),   y,   m_y[i]);
      check($sformatf("model_v%0d", i),   v,   m_v[i]);
      check($sformatf("model_fly%0d", i), fl,  (m_st[i] == ST_FLY) ? 1 : 0);
      check($sformatf("model_gnd%0d", i), gr,  (m_st[i] == ST_DEAD) ? 1 : 0);
      check($sformatf("model_hit%0d", i), hit, m_hit[i]);
   endtask

   task automatic cycle(input bit r, input bit g, input bit m);
      rst = r;
      u_if_a.game_rst = g; u_if_b.game_rst = g; u_if_c.game_rst = g;
      u_if_a.mouse_left = m; u_if_b.mouse_left = m; u_if_c.mouse_left = m;
      @(posedge clk);
      for (int i = 0; i < 3; i++) step_model(i, r | g, m);
      @(negedge clk);
      cmp_one(0, u_if_a.BIRD_Y, u_if_a.bird_vel, u_if_a.flying, u_if_a.grounded, u_if_a.hit_floor);
      cmp_one(1, u_if_b.BIRD_Y, u_if_b.bird_vel, u_if_b.flying, u_if_b.grounded, u_if_b.hit_floor);
      cmp_one(2, u_if_c.BIRD_Y, u_if_c.bird_vel, u_if_c.flying, u_if_c.grounded, u_if_c.hit_floor);
   endtask

   initial begin
      int exp_y[8];
      int reloads, prev_v, max_v, hits, budget, pp;
      exp_y = '{294, 289, 285, 282, 280, 279, 279, 280};
      n_checks = 0;
      n_fail   = 0;

      // Reset state
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      check("rst_y", u_if_a.BIRD_Y, 300);
      check("rst_v", u_if_a.bird_vel, 0);
      check("rst_fly", u_if_a.flying, 0);
      check("rst_gnd", u_if_a.grounded, 0);
      check("rst_hit", u_if_a.hit_floor, 0);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      check("idle_y", u_if_a.BIRD_Y, 300);

      // Launch, ceiling (engine b), coincident click (engine c)
      cycle(0, 0, 1);
      check("launch_pre_fly", u_if_a.flying, 0);
      cycle(0, 0, 0);
      check("launch_fly", u_if_a.flying, 1);
      check("launch_v", u_if_a.bird_vel, -6);
      check("launch_y", u_if_a.BIRD_Y, 300);
      for (int k = 1; k <= 9; k++) begin
         repeat (TD) cycle(0, 0, 0);
         if (k <= 8) check($sformatf("launch_tick%0d_y", k), u_if_a.BIRD_Y, exp_y[k-1]);
         if (k == 6) check("launch_tick6_v", u_if_a.bird_vel, 0);
         if (k == 1) begin
            check("ceil_t1_y", u_if_b.BIRD_Y, 0);
            check("ceil_t1_v", u_if_b.bird_vel, 0);
         end
         if (k == 2) begin
            check("ceil_t2_y", u_if_b.BIRD_Y, 0);
            check("ceil_t2_v", u_if_b.bird_vel, 1);
         end
         if (k == 9) begin
            check("coin_pre_y", u_if_c.BIRD_Y, 400);
            check("coin_pre_v", u_if_c.bird_vel, 3);
         end
      end
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      cycle(0, 0, 1);
      cycle(0, 0, 0);
      check("coin_y", u_if_c.BIRD_Y, 403);
      check("coin_v", u_if_c.bird_vel, -6);
      check("coin_a_y", u_if_a.BIRD_Y, 285);
      check("coin_a_v", u_if_a.bird_vel, -6);

      // Restart mid-flight
      cycle(0, 1, 0);
      check("rst_mid_y", u_if_a.BIRD_Y, 300);
      check("rst_mid_v", u_if_a.bird_vel, 0);
      check("rst_mid_fly", u_if_a.flying, 0);

      // Held button: exactly one reload while held
      reloads = 0;
      prev_v  = 0;
      for (int c = 0; c < 50; c++) begin
         cycle(0, 0, 1);
         if (u_if_a.bird_vel == -6 && prev_v != -6) reloads++;
         prev_v = u_if_a.bird_vel;
      end
      check("hold_reloads", reloads, 1);
      check("hold_v_not_jump", (u_if_a.bird_vel != -6) ? 1 : 0, 1);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      cycle(0, 0, 1);
      cycle(0, 0, 0);
      check("repress_v", u_if_a.bird_vel, -6);

      // Free fall to the floor
      cycle(0, 1, 0);
      cycle(0, 0, 1);
      cycle(0, 0, 0);
      max_v = -100;
      hits = 0;
      budget = 3000;
      while (u_if_a.grounded !== 1'b1 && budget > 0) begin
         cycle(0, 0, 0);
         if (u_if_a.bird_vel > max_v) max_v = u_if_a.bird_vel;
         if (u_if_a.hit_floor === 1'b1) hits++;
         budget--;
      end
      check("floor_reached", (budget > 0) ? 1 : 0, 1);
      check("floor_max_v", max_v, 8);
      check("floor_y", u_if_a.BIRD_Y, 668);
      check("floor_hit", u_if_a.hit_floor, 1);
      check("floor_fly", u_if_a.flying, 0);
      check("floor_v", u_if_a.bird_vel, 0);
      for (int c = 0; c < 30; c++) begin
         cycle(0, 0, (c % 3) == 1);
         if (u_if_a.hit_floor === 1'b1) hits++;
         check("dead_y", u_if_a.BIRD_Y, 668);
         check("dead_v", u_if_a.bird_vel, 0);
         check("dead_gnd", u_if_a.grounded, 1);
      end
      check("floor_hit_count", hits, 1);

      // Restart from DEAD; no motion until a click, first tick TD cycles later
      cycle(0, 1, 0);
      check("rst_dead_y", u_if_a.BIRD_Y, 300);
      check("rst_dead_gnd", u_if_a.grounded, 0);
      check("rst_dead_v", u_if_a.bird_vel, 0);
      repeat (20) cycle(0, 0, 0);
      check("rst_dead_still", u_if_a.BIRD_Y, 300);
      cycle(0, 0, 1);
      cycle(0, 0, 0);
      repeat (TD - 1) cycle(0, 0, 0);
      check("first_tick_pre", u_if_a.BIRD_Y, 300);
      cycle(0, 0, 0);
      check("first_tick_y", u_if_a.BIRD_Y, 294);

      // Randomized traffic against the model
      pp = 10;
      for (int c = 0; c < 4000; c++) begin
         if ((c % 250) == 0) pp = $urandom_range(0, 40);
         cycle(($urandom_range(0, 999) == 0),
               ($urandom_range(0, 299) == 0),
               ($urandom_range(0, 99) < pp));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
